// File: rtl/qspi_flash_selftest.sv
// qspi_flash_selftest: mode-0 SPI self-test of an N25Q flash (JEDEC ID, program, poll, read back, compare).
// Result on status_led: [0]=done, [1]=pass.
`timescale 1ns/1ps
module qspi_flash_selftest #(
  parameter int          SCK_HALF  = 2,
  parameter int          CS_GAP    = 8,
  parameter logic [15:0] EXP_ID    = 16'h20BA,
  parameter logic [23:0] TEST_ADDR = 24'h000000,
  parameter int          NBYTES    = 16,
  parameter logic [23:0] WIP_TMO   = 24'd5_000_000
) (
  input  logic       CLK_100M,
  input  logic       rst,
  output logic [1:0] status_led,
  output logic       clk_to_mem_out,
  output logic       S,
  inout  wire  [3:0] DQio
);
  typedef enum logic [2:0] {IDLE, RDID, WREN, POLL, PP, READ, DONE} st_t;
  typedef enum logic [1:0] {GAP, XFER, TAIL} ph_t;
  localparam logic [7:0] HALF_M1 = 8'(SCK_HALF - 1);
  localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);
  localparam logic [8:0] LAST = 9'(NBYTES + 3);
  st_t st_q, st_d, go, nxt;
  ph_t ph_q, ph_d;
  logic [7:0] cnt_q, cnt_d, tx_q, tx_d, rx_q, rx_d;
  logic [8:0] idx_q, idx_d;
  logic [23:0] tmo_q, tmo_d;
  logic [2:0] bit_q, bit_d;
  logic sck_q, sck_d, s_q, s_d, fail_q, fail_d, pp_q, pp_d, pass_q, pass_d, done_q, done_d;
  logic tick, last_fall, bad, fin;
  function automatic logic [7:0] pat(logic [8:0] i);
    return (i[7:0] - 8'd4) ^ 8'hA5;
  endfunction
  // Byte i of the frame sent while in state st (index 0 is the opcode).
  function automatic logic [7:0] tx_byte(st_t st, logic [8:0] i);
    return i == 9'd0 ? (st == RDID ? 8'h9F : st == WREN ? 8'h06 : st == POLL ? 8'h05 : st == PP ? 8'h02 : 8'h03)
         : (st != PP && st != READ) ? 8'h00
         : i == 9'd1 ? TEST_ADDR[23:16] : i == 9'd2 ? TEST_ADDR[15:8] : i == 9'd3 ? TEST_ADDR[7:0]
         : st == PP ? pat(i) : 8'h00;
  endfunction
  always_comb begin
    st_d = st_q; ph_d = ph_q; cnt_d = cnt_q; tx_d = tx_q; rx_d = rx_q; idx_d = idx_q; tmo_d = tmo_q;
    bit_d = bit_q; sck_d = sck_q; s_d = s_q; fail_d = fail_q; pp_d = pp_q; pass_d = pass_q; done_d = done_q;
    go = st_q == IDLE ? RDID : st_q;
    nxt = st_q == RDID ? WREN : st_q == WREN ? POLL : st_q == POLL ? (pp_q ? READ : PP) : st_q == PP ? POLL : DONE;
    tick = cnt_q == HALF_M1;
    last_fall = ph_q == XFER && tick && sck_q && bit_q == 3'd7;
    // rx_q holds the just-completed byte idx_q at the last falling edge of that byte.
    bad = (st_q == RDID && idx_q == 9'd1 && rx_q != EXP_ID[15:8])
       || (st_q == RDID && idx_q == 9'd2 && rx_q != EXP_ID[7:0])
       || (st_q == POLL && idx_q == 9'd1 && !pp_q && !rx_q[1])
       || (st_q == POLL && idx_q != 9'd0 && rx_q[0] && tmo_q == WIP_TMO - 24'd1)
       || (st_q == READ && idx_q > 9'd3 && rx_q != pat(idx_q));
    fin = bad || (st_q == RDID && idx_q == 9'd3) || st_q == WREN
       || (st_q == POLL && idx_q != 9'd0 && !rx_q[0]) || ((st_q == PP || st_q == READ) && idx_q == LAST);
    if (ph_q == GAP) begin
      cnt_d = cnt_q == GAP_M1 ? cnt_q : cnt_q + 8'd1;
      if (cnt_q == GAP_M1 && st_q != DONE) begin
        st_d = go; ph_d = XFER; cnt_d = 8'd0; s_d = 1'b0; sck_d = 1'b0; bit_d = 3'd0;
        idx_d = 9'd0; tmo_d = 24'd0; tx_d = tx_byte(go, 9'd0);
      end
    end else if (ph_q == TAIL) begin
      cnt_d = cnt_q + 8'd1;
      if (tick) begin
        s_d = 1'b1; ph_d = GAP; cnt_d = 8'd0; done_d = st_q == DONE; pass_d = st_q == DONE && !fail_q;
      end
    end else begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
      sck_d = tick ? !sck_q : sck_q;
      if (tick && !sck_q) rx_d = {rx_q[6:0], DQio[1]};
      if (tick && sck_q) begin
        bit_d = bit_q + 3'd1;
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (last_fall) begin
        idx_d = &idx_q ? idx_q : idx_q + 9'd1;
        tmo_d = tmo_q + {23'd0, st_q == POLL && idx_q != 9'd0 && rx_q[0]};
        if (fin) begin
          ph_d = TAIL; fail_d = fail_q | bad; pp_d = pp_q | st_q == PP;
          st_d = (fail_q | bad) ? DONE : nxt;
        end else tx_d = tx_byte(st_q, idx_q + 9'd1);
      end
    end
  end
  always_ff @(posedge CLK_100M or negedge rst)
    if (!rst) begin
      st_q <= IDLE; ph_q <= GAP; cnt_q <= 8'd0; tx_q <= 8'd0; rx_q <= 8'd0; idx_q <= 9'd0; tmo_q <= 24'd0;
      bit_q <= 3'd0; sck_q <= 1'b0; s_q <= 1'b1; fail_q <= 1'b0; pp_q <= 1'b0; pass_q <= 1'b0; done_q <= 1'b0;
    end else begin
      st_q <= st_d; ph_q <= ph_d; cnt_q <= cnt_d; tx_q <= tx_d; rx_q <= rx_d; idx_q <= idx_d; tmo_q <= tmo_d;
      bit_q <= bit_d; sck_q <= sck_d; s_q <= s_d; fail_q <= fail_d; pp_q <= pp_d; pass_q <= pass_d; done_q <= done_d;
    end
  assign status_led = {pass_q, done_q};
  assign clk_to_mem_out = sck_q;
  assign S = s_q;
  assign DQio = {2'b11, 1'bz, tx_q[7]};
endmodule

// File: tb/tb_qspi_flash_selftest.sv
// tb_qspi_flash_selftest: behavioural N25Q flash model plus outcome model for randomized self-test scenarios.
`timescale 1ns/1ps
module tb_qspi_flash_selftest;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] led;
  logic sck, s;
  wire [3:0] dq;
  wire dq0 = dq[0];
  logic f_bit = 1'b0;
  assign dq[1] = s ? 1'bz : f_bit;
  always #5 clk = ~clk;
  qspi_flash_selftest #(.WIP_TMO(24'd100)) dut (
    .CLK_100M(clk), .rst(rst), .status_led(led), .clk_to_mem_out(sck), .S(s), .DQio(dq));
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  logic [7:0] mem [256];
  logic [7:0] cmds [$];
  logic [23:0] f_id;
  bit f_stuck, f_nowel, wel, first, tmg_en;
  int f_busy, f_bad, polls, wip, bitc, pos;
  int v_gap = 0, v_phase = 0, v_lag = 0, v_setup = 0, v_hold = 0;
  logic [7:0] sh, osh, cmd;
  logic [23:0] addr;
  longint t_srise = 0, t_sfall = 0, t_sck = 0, t_rise = 0, t_dq = 0;
  function automatic logic [7:0] resp(int p);
    if (cmd == 8'h9F) return p == 1 ? f_id[23:16] : p == 2 ? f_id[15:8] : p == 3 ? f_id[7:0] : 8'h00;
    if (cmd == 8'h05) return f_stuck ? 8'h03 : {6'd0, wel, wip != 0};
    if (cmd == 8'h03 && p >= 4) return (p - 4 == f_bad) ? 8'h00 : mem[8'(addr[7:0] + p - 4)];
    return 8'h00;
  endfunction
  always @(negedge s) begin
    if (tmg_en && $time - t_srise < 80) v_gap++;
    t_sfall = $time; first = 1; bitc = 0; pos = 0;
  end
  always @(posedge s) begin
    if (tmg_en && !first && $time - t_sck < 20) v_lag++;
    if (pos >= 1 && bitc == 0 && cmd == 8'h06 && !f_nowel) wel = 1;
    if (pos >= 5 && bitc == 0 && cmd == 8'h02) wip = f_busy;
    t_srise = $time;
  end
  always @(sck) if (!s) begin
    if (tmg_en && (first ? $time - t_sfall < 20 : $time - t_sck != 20)) v_phase++;
    first = 0; t_sck = $time;
  end
  always @(posedge sck) if (!s) begin
    if (tmg_en && $time - t_dq < 10) v_setup++;
    t_rise = $time;
    sh = {sh[6:0], dq0};
    bitc++;
    if (bitc == 8) begin
      bitc = 0;
      if (pos == 0) begin cmd = sh; cmds.push_back(sh); end
      else if (pos <= 3) addr = {addr[15:0], sh};
      else if (cmd == 8'h02) mem[8'(addr[7:0] + pos - 4)] = sh;
      if (cmd == 8'h05 && pos >= 1) begin
        polls++;
        if (wip > 0) wip--;
      end
      pos++;
    end
  end
  always @(negedge sck) if (!s) begin
    if (bitc == 0) osh = resp(pos);
    f_bit = osh[7];
    osh = {osh[6:0], 1'b0};
  end
  always @(dq0) if (!s) begin
    if (tmg_en && $time - t_rise < 10) v_hold++;
    t_dq = $time;
  end
  task automatic check_reset(input string nm);
    check({nm, ":rst_led"}, led, 2'b00);
    check({nm, ":rst_S"}, s, 1);
    check({nm, ":rst_sck"}, sck, 0);
    check({nm, ":rst_dq32"}, dq[3:2], 2'b11);
    check({nm, ":rst_dq0"}, dq0, 0);
  endtask
  task automatic clear_flash();
    cmds.delete(); polls = 0; wel = 0; wip = 0;
  endtask
  task automatic run(input string nm, input logic [23:0] id, input bit stk, input bit nowel,
                     input int busy, input int bad, input int rst_at);
    logic [7:0] exp_cmds [$];
    logic [1:0] exp_led;
    int exp_polls, nbad, waited;
    bit prog;
    tmg_en = 0; rst = 0;
    f_id = id; f_stuck = stk; f_nowel = nowel; f_busy = busy; f_bad = bad;
    clear_flash();
    foreach (mem[i]) mem[i] = 8'hFF;
    #150;
    check_reset(nm);
    @(negedge clk) rst = 1; tmg_en = 1;
    if (rst_at > 0) begin
      repeat (rst_at) @(negedge clk);
      check({nm, ":mid_pp"}, (cmds.size() > 0 && !s) ? cmds[cmds.size() - 1] : 8'h00, 8'h02);
      tmg_en = 0; rst = 0;
      #2;
      check_reset({nm, "_mid"});
      repeat (4) @(negedge clk);
      clear_flash();
      rst = 1; tmg_en = 1;
    end
    waited = 0;
    while (led[0] !== 1'b1 && waited < 20000) begin @(negedge clk); waited++; end
    check({nm, ":done_in_time"}, waited < 20000, 1);
    repeat (5) @(negedge clk);
    exp_cmds = '{8'h9F};
    exp_led = 2'b01; exp_polls = 0; prog = 0;
    if (id[23:8] == 16'h20BA) begin
      exp_cmds.push_back(8'h06); exp_cmds.push_back(8'h05);
      if (nowel) exp_polls = 1;
      else if (stk) exp_polls = 100;
      else begin
        prog = 1;
        exp_cmds.push_back(8'h02); exp_cmds.push_back(8'h05);
        exp_polls = 1 + (busy >= 100 ? 100 : busy + 1);
        if (busy < 100) begin
          exp_cmds.push_back(8'h03);
          exp_led = (bad >= 0 && bad < 16) ? 2'b01 : 2'b11;
        end
      end
    end
    check({nm, ":led"}, led, exp_led);
    check({nm, ":ncmds"}, cmds.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size(); i++)
      check($sformatf("%s:cmd%0d", nm, i), i < cmds.size() ? longint'(cmds[i]) : -1, exp_cmds[i]);
    check({nm, ":polls"}, polls, exp_polls);
    check({nm, ":idle_S"}, s, 1);
    check({nm, ":idle_sck"}, sck, 0);
    if (prog) begin
      nbad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] != (8'(i) ^ 8'hA5)) nbad++;
      check({nm, ":mem"}, nbad, 0);
    end
  endtask
  initial begin
    #2;
    run("pass", 24'h20BA18, 0, 0, 3, -1, 0);
    run("bad_id", 24'hFFFF00, 0, 0, 0, -1, 0);
    run("stuck_sr", 24'h20BA18, 1, 0, 0, -1, 0);
    run("no_wel", 24'h20BA18, 0, 1, 0, -1, 0);
    run("corrupt5", 24'h20BA18, 0, 0, 2, 5, 0);
    run("busy99", 24'h20BA18, 0, 0, 99, -1, 0);
    run("busy100", 24'h20BA18, 0, 0, 100, -1, 0);
    run("rst_mid_pp", 24'h20BA18, 0, 0, 4, -1, $urandom_range(320, 850));
    for (int k = 0; k < 6; k++) begin
      int mode;
      logic [23:0] id;
      mode = $urandom_range(0, 3);
      id = mode == 1 ? {16'h20BA ^ 16'(1 << $urandom_range(0, 15)), 8'($urandom)} : {16'h20BA, 8'($urandom)};
      run($sformatf("rand%0d_m%0d", k, mode), id, 0, 0, $urandom_range(0, 30),
          mode == 2 ? $urandom_range(0, 15) : -1, mode == 3 ? $urandom_range(320, 850) : 0);
    end
    check("s_gap_viol", v_gap, 0);
    check("sck_phase_viol", v_phase, 0);
    check("s_lag_viol", v_lag, 0);
    check("dq0_setup_viol", v_setup, 0);
    check("dq0_hold_viol", v_hold, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
